// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// 32-entry x 32-bit general-purpose register file for the RV32I datapath.
// Register x0 has no storage and always reads as zero. Both read ports are
// purely combinational. The single write port updates on the rising edge of
// clk. There is no read-during-write bypass: a read of the register being
// written returns the old value until the edge and the new value after it.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rst       - synchronous reset, active-low; clears x1..x31, overrides writes
//   wr_ena    - write enable
//   wr_addr   - write register index (0..31); writes to index 0 are dropped
//   wr_data   - write data
//   rd_addr0  - read port 0 register index
//   rd_data0  - read port 0 data (combinational)
//   rd_addr1  - read port 1 register index
//   rd_data1  - read port 1 data (combinational)
//
// Only N = 32 is supported. The register count (32) and the address width (5)
// are fixed.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    // Only x1..x31 are stored; x0 is synthesised away as a constant zero.
    logic [N-1:0] regs [1:31];

    // Write port: a 5-to-32 decode gated by wr_ena. Index 0 never matches a
    // storage entry, so writes to x0 fall away without an extra check.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: resetting this array is deliberate; it is a bank of flops,
            // not a RAM macro, and software relies on every entry reading 0.
            for (int i = 1; i < 32; i++) begin
                // NOTE: non-blocking assignments keep every flop sampling its
                // inputs from before the edge, whatever the statement order.
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_ena && (wr_addr == 5'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Read ports: two independent 32:1 muxes with index 0 forced to zero.
    always_comb begin
        // NOTE: the zero default covers index 0 and keeps this block from
        // inferring a latch on any path that matches no entry.
        rd_data0 = '0;
        rd_data1 = '0;
        for (int i = 1; i < 32; i++) begin
            if (rd_addr0 == 5'(i)) begin
                rd_data0 = regs[i];
            end
            if (rd_addr1 == 5'(i)) begin
                rd_data1 = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register values, x0 pinned to zero.
    logic [31:0] model [32];

    register_file #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Write one register: drive at negedge, commit at posedge, then drop
    // wr_ena and scramble wr_data so late data activity cannot leak in.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_ena  = 1'b0;
        wr_data = $urandom;
        if (a != 5'd0) model[a] = d;
    endtask

    // Read both ports combinationally and compare against the model.
    task automatic read_check(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        rd_addr0 = a0;
        rd_addr1 = a1;
        #1;
        check($sformatf("%s p0 x%0d", tag, a0), rd_data0, model[a0]);
        check($sformatf("%s p1 x%0d", tag, a1), rd_data1, model[a1]);
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < 32; i++) read_check(tag, 5'(i), 5'(31 - i));
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [4:0]  a;
        logic [31:0] d;

        rst      = 1'b0;
        wr_ena   = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hFFFF_FFFF;
        rd_addr0 = '0;
        rd_addr1 = '0;
        model_clear();

        // Reset with a competing write to x5: reset wins.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        wr_ena = 1'b0;
        sweep_all("reset");
        read_check("reset_x5", 5'd5, 5'd5);

        // Randomised write/readback sweep.
        for (int n = 0; n < 1000; n++) begin
            a = 5'($urandom_range(1, 31));
            d = $urandom;
            do_write(a, d);
            read_check("sweep", a, a);
            if (n % 50 == 0) begin
                read_check("sweep_rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
        end
        sweep_all("after_sweep");

        // Enable gating.
        do_write(5'd7, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wr_ena  = 1'b0;
            wr_addr = 5'd7;
            wr_data = 32'h1234_5678;
            @(posedge clk);
            #1;
            read_check("gate", 5'd7, 5'd7);
        end
        check("gate_const", rd_data0, 32'hDEAD_BEEF);

        // x0 hardwire.
        do_write(5'd0, 32'hA5A5_A5A5);
        read_check("x0", 5'd0, 5'd0);
        check("x0_const", rd_data1, 32'h0000_0000);
        sweep_all("x0_others");

        // Dual-port independence with a combinational swap.
        do_write(5'd3, 32'h0000_0003);
        do_write(5'd31, 32'h8000_0000);
        @(negedge clk);
        rd_addr0 = 5'd3;
        rd_addr1 = 5'd31;
        #1;
        check("dual p0", rd_data0, 32'h0000_0003);
        check("dual p1", rd_data1, 32'h8000_0000);
        rd_addr0 = 5'd31;
        rd_addr1 = 5'd3;
        #1;
        check("swap p0", rd_data0, 32'h8000_0000);
        check("swap p1", rd_data1, 32'h0000_0003);

        // Read during write: old value before the edge, new value after.
        do_write(5'd9, 32'h1111_1111);
        @(negedge clk);
        rd_addr0 = 5'd9;
        rd_addr1 = 5'd0;
        wr_ena   = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h2222_2222;
        #1;
        check("rdw_before", rd_data0, 32'h1111_1111);
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        model[9] = 32'h2222_2222;
        check("rdw_after", rd_data0, 32'h2222_2222);

        // Random dual-port reads, x0 included.
        for (int n = 0; n < 40; n++) begin
            read_check("rand_rd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Mid-operation reset: no effect until the edge, then all zero.
        @(negedge clk);
        rst     = 1'b0;
        wr_ena  = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h3333_3333;
        read_check("mid_rst_pre", 5'd9, 5'd31);
        @(posedge clk);
        #1;
        model_clear();
        rst    = 1'b1;
        wr_ena = 1'b0;
        sweep_all("mid_rst_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
